// File: rtl/scrambler_par.sv
// scrambler_par: parallel multi-mode Galois LFSR scrambler.
// Each accepted beat advances the LFSR by DATA_W bit-steps in one cycle. The
// step chain is fully unrolled, and the result is held in one registered
// output stage that uses a valid/ready handshake on both sides.
module scrambler_par #(
   parameter int unsigned           STATE_W = 86,
   parameter int unsigned           DATA_W  = 15,
   parameter logic [STATE_W-1:0]    TAPS    = (STATE_W'(1) << 32) | (STATE_W'(1) << 47)
                                            | (STATE_W'(1) << 56) | (STATE_W'(1) << 65)
                                            | (STATE_W'(1) << 78),
   parameter logic [STATE_W-1:0]    SEED    = '0,
   parameter int unsigned           CNT_W   = 32
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                seed_load,
   input  logic [STATE_W-1:0]  seed_in,
   input  logic                in_valid,
   output logic                in_ready,
   input  logic [DATA_W-1:0]   in_data,
   input  logic [1:0]          in_mode,
   output logic                out_valid,
   input  logic                out_ready,
   output logic [DATA_W-1:0]   out_data,
   output logic [STATE_W-1:0]  state_out,
   output logic [CNT_W-1:0]    beat_cnt,
   output logic                lock_err
);

   // Bit 0 never takes feedback: it is the serial entry point of the register.
   localparam logic [STATE_W-1:0] C_TAPS     = TAPS & ~STATE_W'(1);
   localparam logic [1:0]         C_MODE_ACC = 2'd0;
   localparam logic [1:0]         C_MODE_ADD = 2'd1;

   logic [STATE_W-1:0] r_state;
   logic               r_out_valid;
   logic [DATA_W-1:0]  r_out_data;
   logic [CNT_W-1:0]   r_beat_cnt;
   logic               r_lock_err;

   logic               w_accept;
   logic               w_ready;
   logic               w_mode_acc;
   logic               w_mode_add;
   logic               w_bypass;
   logic [STATE_W-1:0] w_base;
   logic [STATE_W-1:0] w_chain [DATA_W+1];
   logic [DATA_W-1:0]  w_o;

   logic [STATE_W-1:0] w_state_nxt;
   logic               w_out_valid_nxt;
   logic [DATA_W-1:0]  w_out_data_nxt;
   logic [CNT_W-1:0]   w_beat_cnt_nxt;
   logic               w_lock_err_nxt;

   // Handshake and mode decode; codes 2 and 3 both select bypass.
   assign w_ready    = !r_out_valid || out_ready;
   assign w_accept   = in_valid && w_ready;
   assign w_mode_acc = (in_mode == C_MODE_ACC);
   assign w_mode_add = (in_mode == C_MODE_ADD);
   assign w_bypass   = in_mode[1];

   // A seed loaded this cycle is the starting point for a beat accepted alongside it.
   assign w_base     = seed_load ? seed_in : r_state;
   assign w_chain[0] = w_base;

   // Unrolled step chain: stage g consumes in_data[g]; bit 0 is processed first.
   for (genvar g = 0; g < DATA_W; g++) begin : g_step
      logic               w_m;
      logic               w_in0;
      logic [STATE_W-1:0] w_nxt;

      assign w_m   = w_chain[g][STATE_W-1];
      assign w_in0 = w_mode_acc ? (w_m ^ in_data[g]) : w_m;
      assign w_nxt = {w_chain[g][STATE_W-2:0], w_in0} ^ (C_TAPS & {STATE_W{w_m}});
      assign w_chain[g+1] = w_bypass ? w_chain[g] : w_nxt;
      assign w_o[g]       = w_bypass ? in_data[g] : (in_data[g] ^ w_m);
   end

   // Next-state selection for the output stage, counter and sticky lock flag.
   always_comb begin
      w_state_nxt     = w_base;
      w_out_valid_nxt = r_out_valid;
      w_out_data_nxt  = r_out_data;
      w_beat_cnt_nxt  = r_beat_cnt;
      w_lock_err_nxt  = r_lock_err;

      if (seed_load) begin
         w_lock_err_nxt = 1'b0;
      end

      if (w_accept) begin
         w_state_nxt     = w_chain[DATA_W];
         w_out_valid_nxt = 1'b1;
         w_out_data_nxt  = w_o;
         w_beat_cnt_nxt  = r_beat_cnt + CNT_W'(1);
         if (w_mode_add && ((w_base == '0) || (w_chain[DATA_W] == '0))) begin
            w_lock_err_nxt = 1'b1;
         end
      end else if (out_ready) begin
         w_out_valid_nxt = 1'b0;
      end
   end

   // State register; reset overrides seed loads and accepts and drops any pending beat.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state     <= SEED;
         r_out_valid <= 1'b0;
         r_out_data  <= '0;
         r_beat_cnt  <= '0;
         r_lock_err  <= 1'b0;
      end else begin
         r_state     <= w_state_nxt;
         r_out_valid <= w_out_valid_nxt;
         r_out_data  <= w_out_data_nxt;
         r_beat_cnt  <= w_beat_cnt_nxt;
         r_lock_err  <= w_lock_err_nxt;
      end
   end

   assign in_ready  = w_ready;
   assign out_valid = r_out_valid;
   assign out_data  = r_out_data;
   assign state_out = r_state;
   assign beat_cnt  = r_beat_cnt;
   assign lock_err  = r_lock_err;

endmodule
